// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: scanner code and entry handshake on one side, controller outputs on the other.
// The master side drives key_num/entry_ready; the controller is the slave.
interface keypad_entry_ctrl_if;
    logic [3:0]  key_num;
    logic        key_event;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        entry_valid;
    logic [15:0] entry_data;
    logic [2:0]  entry_len;
    logic        entry_ready;
    logic        overflow;

    modport master (
        output key_num, entry_ready,
        input  key_event, key_code, digits, count,
        input  entry_valid, entry_data, entry_len, overflow
    );

    modport slave (
        input  key_num, entry_ready,
        output key_event, key_code, digits, count,
        output entry_valid, entry_data, entry_len, overflow
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Debounced keypad press detector with a 4-digit BCD entry buffer and a valid/ready entry output.
// Define KEYPAD_BACKSPACE_EN to make '*' delete the newest digit instead of clearing the buffer.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_entry_ctrl_if.slave   bus
);
    localparam int       MAX_DIGITS = 4;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYC - 1);
    localparam logic [3:0] K_STAR   = 4'd1;
    localparam logic [3:0] K_HASH   = 4'd2;

    typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_sample;
    logic [3:0]  r_cand;
    logic        r_key_event;
    logic [3:0]  r_key_code;
    logic [15:0] r_digits;
    logic [2:0]  r_count;
    logic        r_entry_valid;
    logic [15:0] r_entry_data;
    logic [2:0]  r_entry_len;
    logic        r_overflow;

    logic        w_accept;
    logic        w_is_digit;
    logic        w_take;
    logic        w_full;

    // A press is accepted on the edge the debounce counter completes with the code still stable.
    assign w_accept   = (r_state == DEB) && (r_sample == r_cand) && (r_cnt == CNT_LAST);
    assign w_is_digit = (r_cand >= 4'd3) && (r_cand <= 4'd12);
    assign w_take     = r_entry_valid && bus.entry_ready;
    assign w_full     = (r_count == 3'(MAX_DIGITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sample      <= '0;
            r_cand        <= '0;
            r_key_event   <= 1'b0;
            r_key_code    <= '0;
            r_digits      <= '0;
            r_count       <= '0;
            r_entry_valid <= 1'b0;
            r_entry_data  <= '0;
            r_entry_len   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_sample    <= (bus.key_num > 4'd12) ? 4'd0 : bus.key_num;
            r_key_event <= 1'b0;
            r_overflow  <= 1'b0;
            if (w_take)
                r_entry_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_sample != 4'd0) begin
                        r_state <= DEB;
                        r_cand  <= r_sample;
                        r_cnt   <= '0;
                    end
                end
                DEB: begin
                    if (r_sample != r_cand) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= PRESSED;
                        r_key_event <= 1'b1;
                        r_key_code  <= r_cand;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                PRESSED: begin
                    if (r_sample == 4'd0) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end
                end
                REL: begin
                    if (r_sample != 4'd0)
                        r_state <= PRESSED;
                    else if (r_cnt == CNT_LAST)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                if (w_is_digit) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_digits <= {r_digits[11:0], r_cand - 4'd3};
                        r_count  <= r_count + 3'd1;
                    end
                end else if (r_cand == K_HASH) begin
                    if (r_count != 3'd0) begin
                        // A commit on the consuming edge overrides the valid clear above.
                        if (!r_entry_valid || bus.entry_ready) begin
                            r_entry_data  <= r_digits;
                            r_entry_len   <= r_count;
                            r_entry_valid <= 1'b1;
                            r_digits      <= '0;
                            r_count       <= '0;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end else if (r_cand == K_STAR) begin
                    if (r_count != 3'd0) begin
`ifdef KEYPAD_BACKSPACE_EN
                        r_digits <= {4'd0, r_digits[15:4]};
                        r_count  <= r_count - 3'd1;
`else
                        r_digits <= '0;
                        r_count  <= '0;
`endif
                    end
                end
            end
        end
    end

    assign bus.key_event   = r_key_event;
    assign bus.key_code    = r_key_code;
    assign bus.digits      = r_digits;
    assign bus.count       = r_count;
    assign bus.entry_valid = r_entry_valid;
    assign bus.entry_data  = r_entry_data;
    assign bus.entry_len   = r_entry_len;
    assign bus.overflow    = r_overflow;
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: consecutive sampled cycles a code (or release) SHALL be stable before acceptance; legal range 2..255.
REQ-002 Parameter MAX_DIGITS, fixed 4: digit buffer depth in BCD nibbles.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 key_num  in  4  keypad scanner code: 0 none, 1 '*', 2 '#', 3..12 digits 0..9; 13..15 SHALL be treated as 0.
REQ-006 key_event  out  1  one-cycle pulse per accepted press.
REQ-007 key_code  out  4  code of the last accepted press, held until the next press.
REQ-008 digits  out  16  entry buffer, newest digit in [3:0], unused nibbles 0.
REQ-009 count  out  3  number of digits in buffer, 0..4.
REQ-010 entry_valid  out  1  completed entry available.
REQ-011 entry_data  out  16  committed digits, same layout as digits.
REQ-012 entry_len  out  3  committed digit count, 1..4.
REQ-013 entry_ready  in  1  consumer accepts the entry when high with entry_valid at a clock edge.
REQ-014 overflow  out  1  one-cycle pulse when a press is discarded.

Function
REQ-015 key_num SHALL be registered once into a sample register before any decision.
REQ-016 Press FSM states: IDLE, DEB, PRESSED, REL; debounce counter 8 bits.
REQ-017 IDLE: sample nonzero -> DEB, latch candidate, counter 0.
REQ-018 DEB: sample != candidate -> IDLE; counter == DEBOUNCE_CYC-1 -> PRESSED with key_event=1 for that one cycle; else counter+1.
REQ-019 PRESSED: sample == 0 -> REL, counter 0; any nonzero sample (including a different code) stays PRESSED without a new event.
REQ-020 REL: sample nonzero -> PRESSED; counter == DEBOUNCE_CYC-1 -> IDLE; else counter+1.
REQ-021 Latency: key_event SHALL be high in the cycle after the (DEBOUNCE_CYC+2)th posedge counted from the first posedge at which key_num shows a stable nonzero code.
REQ-022 Digit event, count<4: digits shifts left one nibble, new digit (code-3) into [3:0], count+1; count==4: buffer unchanged, overflow pulse.
REQ-023 '#' event, count>0, entry_valid low: entry_data<=digits, entry_len<=count, entry_valid<=1, digits<=0, count<=0.
REQ-024 '#' event, count==0: ignored, no overflow.
REQ-025 '#' event, count>0, entry_valid high and entry_ready low: buffer retained, overflow pulse.
REQ-026 entry_valid high and entry_ready high at an edge: entry_valid clears; if a '#' commit (REQ-023) occurs on the same edge, the new entry is loaded and entry_valid stays 1.
REQ-027 '*' event behaviour per REQ-031/REQ-032; '*' at count==0 SHALL be a no-op.
REQ-028 entry_data/entry_len SHALL stay stable while entry_valid is high.

Reset
REQ-029 rst high SHALL immediately force FSM=IDLE, counter, sample, candidate, key_code, digits, count, entry_data, entry_len = 0, and key_event, entry_valid, overflow = 0, including mid-debounce or while an entry is pending.
REQ-030 After rst deasserts with a key already held, the key SHALL be accepted once after full debounce.

Configuration
REQ-031 Macro KEYPAD_BACKSPACE_EN defined: '*' SHALL delete the newest digit (digits shifts right one nibble, 0 into [15:12], count-1).
REQ-032 Macro undefined: '*' SHALL clear the whole buffer (digits=0, count=0); pending entry unaffected in both modes.

Verification
REQ-033 DEBOUNCE_CYC=4; key_num=3 held 20 cycles then 0 -> exactly one key_event, key_code=3, digits=0x0000, count=1; event on cycle 7 per REQ-021.
REQ-034 Bounce: key_num toggles 5/0 every 2 cycles for 12 cycles, then 5 stable -> one key_event only after stability; no event during toggling.
REQ-035 Press 1,2,3,4,5 (codes 4,5,6,7,8) -> digits=0x1234, count=4, overflow pulse on 5th; then '#' -> entry_valid=1, entry_data=0x1234, entry_len=4, count=0.
REQ-036 With entry pending and entry_ready=0: enter 7,'#' -> overflow pulse, digits=0x0007 kept; raise entry_ready and press '#' on the same edge -> entry_data=0x0007, entry_len=1, entry_valid stays 1.
REQ-037 digits=0x0123 then '*' -> with KEYPAD_BACKSPACE_EN: 0x0012, count=2; without: 0x0000, count=0; rst pulsed mid-DEB -> all outputs 0 within same cycle, no key_event.
